// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the MEM stage (master) and the latency-modelling responder (slave).
// A request is MemRead|MemWrite; the master holds it while busy=1 and the transfer completes in the done cycle.
interface data_memory_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output MemRead, MemWrite, address, write_data,
    input  read_data, busy, done, error
  );

  modport slave (
    input  MemRead, MemWrite, address, write_data,
    output read_data, busy, done, error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency 64-bit word memory responder: IDLE -> WAIT (LATENCY edges) -> DONE -> IDLE.
// Requests are latched on acceptance; the array is committed only on the edge entering DONE.
module data_memory_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  data_memory_responder_if.slave     bus,
  output logic [1:0]                 dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAT4 = LATENCY[3:0];

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  req, illegal, commit, busy_c;
  logic                  lat_write, lat_illegal;
  logic [ADDR_BITS-1:0]  lat_idx;
  logic [63:0]           lat_wdata;
  logic                  acc_write, acc_illegal;
  logic [ADDR_BITS-1:0]  acc_idx;
  logic [63:0]           acc_wdata;
  logic [63:0]           rdata;
  logic [63:0]           mem [0:(1<<ADDR_BITS)-1];

  assign req     = bus.MemRead | bus.MemWrite;
  assign illegal = (bus.MemRead & bus.MemWrite) | (|bus.address[2:0]) |
                   (|bus.address[63:ADDR_BITS+3]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy_c  = 1'b1;
          cnt_nxt = LAT4;
          if (LATENCY == 0) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        busy_c  = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access happens on the acceptance edge, straight from the bus.
  always_comb begin
    acc_write   = lat_write;
    acc_illegal = lat_illegal;
    acc_idx     = lat_idx;
    acc_wdata   = lat_wdata;
    if (state == IDLE) begin
      acc_write   = bus.MemWrite;
      acc_illegal = illegal;
      acc_idx     = bus.address[ADDR_BITS+2:3];
      acc_wdata   = bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rdata       <= 64'd0;
      lat_write   <= 1'b0;
      lat_illegal <= 1'b0;
      lat_idx     <= '0;
      lat_wdata   <= 64'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        lat_write   <= bus.MemWrite;
        lat_illegal <= illegal;
        lat_idx     <= bus.address[ADDR_BITS+2:3];
        lat_wdata   <= bus.write_data;
      end
      if (commit) begin
        if (acc_illegal)     rdata <= 64'd0;
        else if (!acc_write) rdata <= mem[acc_idx];
      end
    end
  end

  // Array contents survive reset; a reset edge simply suppresses the commit.
  always_ff @(posedge clock) begin
    if (!reset && commit && acc_write && !acc_illegal)
      mem[acc_idx] <= acc_wdata;
  end

  assign bus.read_data = rdata;
  assign bus.busy      = busy_c;
  assign bus.done      = (state == DONE);
  assign bus.error     = (state == DONE) & lat_illegal;
  assign dbg_state     = state;
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: table of accesses on a LATENCY=2 instance plus hand-written
// reset, held-request and LATENCY=0 sequences; responses checked against an expected queue.
module tb_data_memory_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_responder_if b2 ();
  data_memory_responder_if b0 ();
  logic [1:0] st2, st0;

  data_memory_responder #(.ADDR_BITS(8), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .bus(b2.slave), .dbg_state(st2)
  );
  data_memory_responder #(.ADDR_BITS(8), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave), .dbg_state(st0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] data;
  } vec_t;

  vec_t         vecs [14];
  logic [64:0]  exp_q [$];
  int           passed = 0;
  int           total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) $display("FAIL %s: got %h expected %h", name, act, exp_v);
    else passed++;
  endtask

  task automatic set_in(input bit sel, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] wd);
    if (sel) begin
      b0.MemRead = rd; b0.MemWrite = wr; b0.address = addr; b0.write_data = wd;
    end else begin
      b2.MemRead = rd; b2.MemWrite = wr; b2.address = addr; b2.write_data = wd;
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? b0.busy : b2.busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? b0.done : b2.done;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? b0.error : b2.error;
  endfunction
  function automatic logic [63:0] get_rdata(input bit sel);
    return sel ? b0.read_data : b2.read_data;
  endfunction

  // Called just after a rising edge with the DUT idle; returns just after the edge leaving DONE.
  task automatic run_access(input bit sel, input logic rd, input logic wr,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic e_err, input logic [63:0] e_data, input int e_busy);
    int          nbusy = 0;
    bit          got   = 0;
    logic [64:0] e;
    exp_q.push_back({e_err, e_data});
    set_in(sel, rd, wr, addr, wd);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (get_done(sel)) begin
        got = 1;
        e = exp_q.pop_front();
        check("busy_in_done", {63'd0, get_busy(sel)}, 64'd0);
        check("busy_cycles", 64'(nbusy), 64'(e_busy));
        check("error", {63'd0, get_err(sel)}, {63'd0, e[64]});
        check("read_data", get_rdata(sel), e[63:0]);
      end else if (get_busy(sel)) begin
        nbusy++;
      end
      @(posedge clock); #1;
      // Scramble the bus after acceptance: the responder must use its latched copy.
      if (c == 0) set_in(sel, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    end
    set_in(sel, 1'b0, 1'b0, 64'd0, 64'd0);
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 64'h10,  64'hDEADBEEFCAFEF00D, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 64'h10,  64'h0,                1'b0, 64'hDEADBEEFCAFEF00D};
    vecs[2]  = '{1'b1, 1'b0, 64'h0C,  64'h0,                1'b1, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 64'h800, 64'h0,                1'b1, 64'h0};
    vecs[4]  = '{1'b1, 1'b1, 64'h10,  64'h1234,             1'b1, 64'h0};
    vecs[5]  = '{1'b1, 1'b0, 64'h10,  64'h0,                1'b0, 64'hDEADBEEFCAFEF00D};
    vecs[6]  = '{1'b0, 1'b1, 64'h18,  64'h1111,             1'b0, 64'hDEADBEEFCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 64'h7F8, 64'hA5A5,             1'b0, 64'hDEADBEEFCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, 64'h7F8, 64'h0,                1'b0, 64'hA5A5};
    vecs[9]  = '{1'b1, 1'b0, 64'h18,  64'h0,                1'b0, 64'h1111};
    vecs[10] = '{1'b1, 1'b0, 64'h8000_0000_0000_0010, 64'h0, 1'b1, 64'h0};
    vecs[11] = '{1'b0, 1'b1, 64'h810, 64'h7777,             1'b1, 64'h0};
    vecs[12] = '{1'b1, 1'b0, 64'h10,  64'h0,                1'b0, 64'hDEADBEEFCAFEF00D};
    vecs[13] = '{1'b1, 1'b0, 64'h14,  64'h0,                1'b1, 64'h0};

    set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

    // Reset held two cycles with no request.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_read_data", b2.read_data, 64'd0);
    check("rst_done", {63'd0, b2.done}, 64'd0);
    check("rst_error", {63'd0, b2.error}, 64'd0);
    check("rst_busy", {63'd0, b2.busy}, 64'd0);
    check("rst_state", {62'd0, st2}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].err, vecs[i].data, 3);

    // Write 0x2222 to 0x18, reset in the first WAIT cycle: write must be discarded.
    set_in(1'b0, 1'b0, 1'b1, 64'h18, 64'h2222);
    @(posedge clock); #1;
    set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("wrst_busy", {63'd0, b2.busy}, 64'd0);
    check("wrst_done", {63'd0, b2.done}, 64'd0);
    check("wrst_error", {63'd0, b2.error}, 64'd0);
    check("wrst_read_data", b2.read_data, 64'd0);
    check("wrst_state", {62'd0, st2}, 64'd0);
    @(posedge clock); #1;
    run_access(1'b0, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 64'h1111, 3);

    // Reset together with a request: nothing is accepted.
    reset = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 64'h18, 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clock);
    check("rreq_state", {62'd0, st2}, 64'd0);
    check("rreq_busy", {63'd0, b2.busy}, 64'd0);
    @(posedge clock); #1;

    // MemRead held continuously: done every 4th cycle, busy low exactly in DONE.
    set_in(1'b0, 1'b1, 1'b0, 64'h10, 64'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      check("held_done", {63'd0, b2.done}, {63'd0, (c % 4) == 3});
      check("held_busy", {63'd0, b2.busy}, {63'd0, (c % 4) != 3});
      if ((c % 4) == 3) check("held_read_data", b2.read_data, 64'hDEADBEEFCAFEF00D);
      @(posedge clock); #1;
    end
    set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clock);
    check("held_end_state", {62'd0, st2}, 64'd0);
    @(posedge clock); #1;

    // LATENCY=0 instance.
    run_access(1'b1, 1'b0, 1'b1, 64'h0, 64'h5, 1'b0, 64'h0, 1);
    run_access(1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 64'h5, 1);
    run_access(1'b1, 1'b1, 1'b0, 64'h3, 64'h0, 1'b1, 64'h0, 1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
